// File: rtl/ysyx_22040386_idu_stage.sv
// ============================================================================
// Module      : ysyx_22040386_idu_stage
// Description : Registered RV32I/RV64I decode stage between IFU and EXU.
//               Decodes one instruction per cycle into a control bundle,
//               tracks pending register writes in a busy-bit scoreboard and
//               stalls RAW/WAW hazards. valid/ready on both sides, flush
//               from branch resolution kills the held entry.
// Ports       : clk, rst (async, active-high)
//               in_valid/in_ready/in_inst/in_pc     : IFU side
//               flush                               : kill held entry
//               out_valid/out_ready/out_*           : EXU side (registered)
//               wb_valid/wb_rd                      : writeback retire
// Parameters  : XLEN (32/64), NREG (scoreboard depth, x0 never busy)
// Config      : IDU_MEXT_EN - decode funct7=0000001 on OP/OP-32 as M-ext
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_22040386_idu_stage #(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [15:0]     out_ctrl,
  output logic [2:0]      out_mask,
  output logic [9:0]      out_funct,
  output logic            out_illegal,
  output logic            out_ebreak,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd
);

  localparam logic [6:0]  c_op_lui    = 7'h37;
  localparam logic [6:0]  c_op_auipc  = 7'h17;
  localparam logic [6:0]  c_op_jal    = 7'h6F;
  localparam logic [6:0]  c_op_jalr   = 7'h67;
  localparam logic [6:0]  c_op_branch = 7'h63;
  localparam logic [6:0]  c_op_load   = 7'h03;
  localparam logic [6:0]  c_op_store  = 7'h23;
  localparam logic [6:0]  c_op_imm    = 7'h13;
  localparam logic [6:0]  c_op_reg    = 7'h33;
  localparam logic [6:0]  c_op_imm32  = 7'h1B;
  localparam logic [6:0]  c_op_reg32  = 7'h3B;
  localparam logic [6:0]  c_op_system = 7'h73;
  localparam logic [6:0]  c_op_fence  = 7'h0F;
  localparam logic [15:0] c_ctrl_reset = 16'h0002;
  localparam logic [6:0]  c_funct7_mext = 7'b0000001;
`ifdef IDU_MEXT_EN
  localparam logic c_mext_en = 1'b1;
`else
  localparam logic c_mext_en = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Instruction fields
  // --------------------------------------------------------------------------
  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic [4:0] w_rd;

  assign w_opcode = in_inst[6:0];
  assign w_funct3 = in_inst[14:12];
  assign w_funct7 = in_inst[31:25];
  assign w_rs1    = in_inst[19:15];
  assign w_rs2    = in_inst[24:20];
  assign w_rd     = in_inst[11:7];

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  logic        w_legal;
  logic        w_dec_rw;
  logic        w_dec_mr;
  logic        w_dec_mw;
  logic        w_dec_asi;
  logic        w_dec_r2m;
  logic        w_dec_r2pc;
  logic        w_dec_word;
  logic        w_dec_jal;
  logic        w_dec_jalr;
  logic        w_dec_lui;
  logic        w_dec_auipc;
  logic [1:0]  w_dec_alu_op;
  logic [2:0]  w_dec_br;
  logic [2:0]  w_dec_mask;
  logic [31:0] w_imm32;
  logic        w_use_rs1;
  logic        w_use_rs2;

  always_comb begin
    w_legal      = 1'b1;
    w_dec_rw     = 1'b0;
    w_dec_mr     = 1'b0;
    w_dec_mw     = 1'b0;
    w_dec_asi    = 1'b0;
    w_dec_r2m    = 1'b0;
    w_dec_r2pc   = 1'b0;
    w_dec_word   = 1'b0;
    w_dec_jal    = 1'b0;
    w_dec_jalr   = 1'b0;
    w_dec_lui    = 1'b0;
    w_dec_auipc  = 1'b0;
    w_dec_alu_op = 2'b00;
    w_dec_br     = 3'b010;
    w_dec_mask   = 3'b000;
    w_imm32      = 32'h0;
    w_use_rs1    = 1'b1;
    w_use_rs2    = 1'b0;
    case (w_opcode)
      c_op_lui: begin
        w_dec_lui = 1'b1;
        w_dec_rw  = 1'b1;
        w_dec_asi = 1'b1;
        w_use_rs1 = 1'b0;
        w_imm32   = {in_inst[31:12], 12'h000};
      end
      c_op_auipc: begin
        w_dec_auipc = 1'b1;
        w_dec_rw    = 1'b1;
        w_dec_asi   = 1'b1;
        w_use_rs1   = 1'b0;
        w_imm32     = {in_inst[31:12], 12'h000};
      end
      c_op_jal: begin
        w_dec_jal  = 1'b1;
        w_dec_r2pc = 1'b1;
        w_dec_rw   = 1'b1;
        w_use_rs1  = 1'b0;
        w_imm32    = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                      in_inst[20], in_inst[30:21], 1'b0};
      end
      c_op_jalr: begin
        w_dec_jalr = 1'b1;
        w_dec_r2pc = 1'b1;
        w_dec_rw   = 1'b1;
        w_dec_asi  = 1'b1;
        w_imm32    = {{20{in_inst[31]}}, in_inst[31:20]};
        if (w_funct3 != 3'b000) w_legal = 1'b0;
      end
      c_op_branch: begin
        w_dec_alu_op = 2'b11;
        w_dec_br     = w_funct3;
        w_use_rs2    = 1'b1;
        w_imm32      = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                        in_inst[30:25], in_inst[11:8], 1'b0};
      end
      c_op_load: begin
        w_dec_mr   = 1'b1;
        w_dec_rw   = 1'b1;
        w_dec_asi  = 1'b1;
        w_dec_mask = w_funct3;
        w_imm32    = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      c_op_store: begin
        w_dec_mw   = 1'b1;
        w_dec_r2m  = 1'b1;
        w_dec_asi  = 1'b1;
        w_dec_mask = w_funct3;
        w_use_rs2  = 1'b1;
        w_imm32    = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      end
      c_op_imm: begin
        w_dec_rw     = 1'b1;
        w_dec_asi    = 1'b1;
        w_dec_alu_op = 2'b01;
        w_imm32      = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      c_op_reg: begin
        w_dec_rw     = 1'b1;
        w_dec_alu_op = 2'b10;
        w_use_rs2    = 1'b1;
        if (w_funct7 == c_funct7_mext && !c_mext_en) w_legal = 1'b0;
      end
      c_op_imm32: begin
        if (XLEN == 64) begin
          w_dec_word   = in_inst[3];
          w_dec_rw     = 1'b1;
          w_dec_asi    = 1'b1;
          w_dec_alu_op = 2'b01;
          w_imm32      = {{20{in_inst[31]}}, in_inst[31:20]};
        end else begin
          w_legal = 1'b0;
        end
      end
      c_op_reg32: begin
        if (XLEN == 64) begin
          w_dec_word   = in_inst[3];
          w_dec_rw     = 1'b1;
          w_dec_alu_op = 2'b10;
          w_use_rs2    = 1'b1;
          if (w_funct7 == c_funct7_mext && !c_mext_en) w_legal = 1'b0;
        end else begin
          w_legal = 1'b0;
        end
      end
      c_op_system, c_op_fence: begin
        w_legal = 1'b1;
      end
      default: begin
        w_legal = 1'b0;
      end
    endcase
  end

  // Undecodable instructions never write a register or touch memory.
  logic        w_reg_write;
  logic [15:0] w_ctrl;
  logic        w_set_busy;

  assign w_reg_write = w_dec_rw & w_legal;
  assign w_ctrl = {w_reg_write, w_dec_mr & w_legal, w_dec_mw & w_legal,
                   w_dec_asi, w_dec_r2m & w_legal, w_dec_r2pc, w_dec_word,
                   w_dec_jal, w_dec_jalr, w_dec_lui, w_dec_auipc,
                   w_dec_alu_op, w_dec_br};
  assign w_set_busy = w_reg_write & (w_rd != 5'd0);

  // --------------------------------------------------------------------------
  // Handshake and hazard detection
  // --------------------------------------------------------------------------
  logic        r_valid;
  logic        r_sets_busy;
  logic [4:0]  r_rd;
  logic [31:0] w_busy;
  logic        w_hazard;
  logic        w_accept;
  logic        w_kill;

  // w_busy[0] is tied low, so index 0 can never hazard.
  assign w_hazard = (w_use_rs1 & w_busy[w_rs1]) |
                    (w_use_rs2 & w_busy[w_rs2]) |
                    (w_reg_write & w_busy[w_rd]);
  assign in_ready = (~r_valid | out_ready) & ~w_hazard & ~flush;
  assign w_accept = in_valid & in_ready;
  // A flushed entry that EXU never consumed will never write back, so its
  // busy bit must be released here.
  assign w_kill   = flush & r_valid & ~out_ready & r_sets_busy;

  // --------------------------------------------------------------------------
  // Busy-bit scoreboard
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < 32; i++) begin : g_busy
    if (i > 0 && i < NREG) begin : g_flop
      logic r_bit;
      logic w_set;
      logic w_clr;
      assign w_set = w_accept & w_set_busy & (w_rd == 5'(i));
      assign w_clr = (wb_valid & (wb_rd == 5'(i))) | (w_kill & (r_rd == 5'(i)));
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_bit <= 1'b0;
        end else begin
          r_bit <= w_set | (r_bit & ~w_clr);
        end
      end
      assign w_busy[i] = r_bit;
    end else begin : g_zero
      assign w_busy[i] = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Output bundle register
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] r_pc;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [XLEN-1:0] r_imm;
  logic [15:0]     r_ctrl;
  logic [2:0]      r_mask;
  logic [9:0]      r_funct;
  logic            r_illegal;
  logic            r_ebreak;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_sets_busy <= 1'b0;
      r_pc        <= '0;
      r_rs1       <= 5'd0;
      r_rs2       <= 5'd0;
      r_rd        <= 5'd0;
      r_imm       <= '0;
      r_ctrl      <= c_ctrl_reset;
      r_mask      <= 3'd0;
      r_funct     <= 10'd0;
      r_illegal   <= 1'b0;
      r_ebreak    <= 1'b0;
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_accept) begin
        r_valid <= 1'b1;
      end else if (r_valid & out_ready) begin
        r_valid <= 1'b0;
      end
      if (w_accept) begin
        r_sets_busy <= w_set_busy;
        r_pc        <= in_pc;
        r_rs1       <= w_rs1;
        r_rs2       <= w_rs2;
        r_rd        <= w_rd;
        r_imm       <= XLEN'($signed(w_imm32));
        r_ctrl      <= w_ctrl;
        r_mask      <= w_dec_mask;
        r_funct     <= {w_funct7, w_funct3};
        r_illegal   <= ~w_legal;
        r_ebreak    <= (in_inst == 32'h0010_0073);
      end
    end
  end

  assign out_valid   = r_valid;
  assign out_pc      = r_pc;
  assign out_rs1     = r_rs1;
  assign out_rs2     = r_rs2;
  assign out_rd      = r_rd;
  assign out_imm     = r_imm;
  assign out_ctrl    = r_ctrl;
  assign out_mask    = r_mask;
  assign out_funct   = r_funct;
  assign out_illegal = r_illegal;
  assign out_ebreak  = r_ebreak;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22040386_idu_stage.sv
// ============================================================================
// Module      : tb_ysyx_22040386_idu_stage
// Description : Scoreboard bench for the IDU stage. A driver applies directed
//               and random instructions, predicts in_ready from a reference
//               busy-set model and queues the expected decoded bundle; a
//               monitor compares the presented bundle against the queue head.
// Config      : IDU_MEXT_EN selects the M-extension expectation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_22040386_idu_stage;

  localparam int TB_XLEN = 64;
`ifdef IDU_MEXT_EN
  localparam bit TB_MEXT = 1'b1;
`else
  localparam bit TB_MEXT = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] imm;
    logic [15:0] ctrl;
    logic [2:0]  mask;
    logic [9:0]  funct;
    logic        illegal;
    logic        ebreak;
    logic        u1;
    logic        u2;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        in_inst;
  logic [TB_XLEN-1:0] in_pc;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [TB_XLEN-1:0] out_pc;
  logic [4:0]         out_rs1;
  logic [4:0]         out_rs2;
  logic [4:0]         out_rd;
  logic [TB_XLEN-1:0] out_imm;
  logic [15:0]        out_ctrl;
  logic [2:0]         out_mask;
  logic [9:0]         out_funct;
  logic               out_illegal;
  logic               out_ebreak;
  logic               wb_valid;
  logic [4:0]         wb_rd;

  ysyx_22040386_idu_stage #(.XLEN(TB_XLEN), .NREG(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_ctrl(out_ctrl), .out_mask(out_mask), .out_funct(out_funct),
    .out_illegal(out_illegal), .out_ebreak(out_ebreak),
    .wb_valid(wb_valid), .wb_rd(wb_rd)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb_q[$];

  // Reference model state: set of registers with a write in flight.
  bit         m_busy[32];
  bit         m_valid;
  bit         m_held_sets;
  logic [4:0] m_held_rd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference decoder: immediates via signed shifts of the instruction word.
  function automatic exp_t ref_decode(input logic [31:0] w, input logic [63:0] pc);
    exp_t e;
    int op, f7, sx, imm;
    bit known, rw, mr, mw, asi, r2m, r2pc, wo, jl, jr, lu, au;
    bit [1:0] aop;
    bit [2:0] bt;
    e = '0;
    op = int'(w[6:0]);
    f7 = int'(w[31:25]);
    sx = int'(w) >>> 31;
    imm = 0; known = 1;
    rw = 0; mr = 0; mw = 0; asi = 0; r2m = 0; r2pc = 0; wo = 0;
    jl = 0; jr = 0; lu = 0; au = 0; aop = 2'd0; bt = 3'd2;
    case (op)
      'h37: begin lu = 1; rw = 1; asi = 1; imm = int'(w & 32'hFFFF_F000); end
      'h17: begin au = 1; rw = 1; asi = 1; imm = int'(w & 32'hFFFF_F000); end
      'h6F: begin
        jl = 1; r2pc = 1; rw = 1;
        imm = (sx <<< 20) | (int'(w[19:12]) << 12) | (int'(w[20]) << 11) | (int'(w[30:21]) << 1);
      end
      'h67: begin
        jr = 1; r2pc = 1; rw = 1; asi = 1; imm = int'(w) >>> 20;
        if (w[14:12] != 3'd0) known = 0;
      end
      'h63: begin
        aop = 2'd3; bt = w[14:12];
        imm = (sx <<< 12) | (int'(w[7]) << 11) | (int'(w[30:25]) << 5) | (int'(w[11:8]) << 1);
      end
      'h03: begin mr = 1; rw = 1; asi = 1; imm = int'(w) >>> 20; e.mask = w[14:12]; end
      'h23: begin
        mw = 1; r2m = 1; asi = 1; e.mask = w[14:12];
        imm = ((int'(w) >>> 25) <<< 5) | int'(w[11:7]);
      end
      'h13: begin rw = 1; asi = 1; aop = 2'd1; imm = int'(w) >>> 20; end
      'h33: begin rw = 1; aop = 2'd2; if (f7 == 1 && !TB_MEXT) known = 0; end
      'h1B: begin
        if (TB_XLEN == 64) begin wo = 1; rw = 1; asi = 1; aop = 2'd1; imm = int'(w) >>> 20; end
        else known = 0;
      end
      'h3B: begin
        if (TB_XLEN == 64) begin
          wo = 1; rw = 1; aop = 2'd2;
          if (f7 == 1 && !TB_MEXT) known = 0;
        end else known = 0;
      end
      'h73, 'h0F: known = 1;
      default: known = 0;
    endcase
    if (!known) begin rw = 0; mr = 0; mw = 0; r2m = 0; end
    e.pc      = pc;
    e.rs1     = w[19:15];
    e.rs2     = w[24:20];
    e.rd      = w[11:7];
    e.imm     = 64'(longint'(imm));
    e.ctrl    = {rw, mr, mw, asi, r2m, r2pc, wo, jl, jr, lu, au, aop, bt};
    e.funct   = {w[31:25], w[14:12]};
    e.illegal = !known;
    e.ebreak  = (w == 32'h0010_0073);
    e.u1      = !(op == 'h37 || op == 'h17 || op == 'h6F);
    e.u2      = (op == 'h33 || op == 'h23 || op == 'h63 || (op == 'h3B && TB_XLEN == 64));
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_busy[i] = 0;
    m_valid = 0; m_held_sets = 0; m_held_rd = 5'd0;
  endtask

  // One clock of stimulus; inputs applied after the edge, checks mid-cycle.
  task automatic step(input bit v, input logic [31:0] w, input bit ordy, input bit fl,
                      input bit wbv, input logic [4:0] wbr);
    exp_t d;
    bit haz, exp_rdy, acc;
    @(posedge clk); #1;
    in_valid = v; in_inst = w; in_pc = {$urandom, $urandom};
    out_ready = ordy; flush = fl; wb_valid = wbv; wb_rd = wbr;
    @(negedge clk);
    d = ref_decode(w, in_pc);
    haz = (d.u1 && m_busy[d.rs1]) || (d.u2 && m_busy[d.rs2]) || (d.ctrl[15] && m_busy[d.rd]);
    exp_rdy = (!m_valid || ordy) && !haz && !fl;
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    acc = v && exp_rdy;
    if (acc) sb_q.push_back(d);
    if (wbv) m_busy[wbr] = 0;
    if (fl && m_valid && !ordy && m_held_sets) m_busy[m_held_rd] = 0;
    if (acc && d.ctrl[15] && d.rd != 5'd0) m_busy[d.rd] = 1;
    m_busy[0] = 0;
    if (fl) m_valid = 0;
    else if (acc) m_valid = 1;
    else if (ordy) m_valid = 0;
    if (acc) begin m_held_sets = d.ctrl[15] && d.rd != 5'd0; m_held_rd = d.rd; end
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    int k;
    w = $urandom;
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    k = $urandom_range(0, 13);
    case (k)
      0: w[6:0] = 7'h37;
      1: w[6:0] = 7'h17;
      2: w[6:0] = 7'h6F;
      3: begin w[6:0] = 7'h67; if ($urandom_range(0, 3) != 0) w[14:12] = 3'd0; end
      4: w[6:0] = 7'h63;
      5: w[6:0] = 7'h03;
      6: w[6:0] = 7'h23;
      7: w[6:0] = 7'h13;
      8: begin w[6:0] = 7'h33; w[31:25] = ($urandom_range(0, 2) == 0) ? 7'h01 : 7'h00; end
      9: w[6:0] = 7'h1B;
      10: begin w[6:0] = 7'h3B; w[31:25] = ($urandom_range(0, 2) == 0) ? 7'h01 : 7'h20; end
      11: w = 32'h0010_0073;
      12: w = ($urandom_range(0, 1) == 0) ? 32'h0000_0073 : 32'h0000_000F;
      default: w[6:0] = ($urandom_range(0, 1) == 0) ? 7'h0B : 7'h7F;
    endcase
    return w;
  endfunction

  // Monitor: compare the presented bundle against the queue head each cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (sb_q.size() == 0) begin
          chk("bundle_expected", 64'(sb_q.size()), 64'd1);
        end else begin
          exp_t e;
          e = sb_q[0];
          chk("out_pc", out_pc, e.pc);
          chk("out_imm", out_imm, e.imm);
          chk("out_ctrl", 64'(out_ctrl), 64'(e.ctrl));
          chk("out_fields",
              64'({out_rs1, out_rs2, out_rd, out_mask, out_funct, out_illegal, out_ebreak}),
              64'({e.rs1, e.rs2, e.rd, e.mask, e.funct, e.illegal, e.ebreak}));
          if (out_ready || flush) void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 0; in_inst = 32'h0; in_pc = '0;
    flush = 0; out_ready = 0; wb_valid = 0; wb_rd = 5'd0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_ctrl", 64'(out_ctrl), 64'h0002);
    chk("reset_imm", out_imm, 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1 rst = 1'b0;

    // addi x5,x0,-1 then add x6,x5,x5 stalls until x5 written back.
    step(1, 32'hFFF0_0293, 1, 0, 0, 5'd0);
    repeat (3) step(1, 32'h0052_8333, 1, 0, 0, 5'd0);
    step(1, 32'h0052_8333, 1, 0, 1, 5'd5);
    step(1, 32'h0052_8333, 1, 0, 0, 5'd0);
    // Back-pressure: bundle held for three cycles, then released.
    repeat (3) step(1, 32'h0010_0413, 0, 0, 0, 5'd0);
    step(1, 32'h0010_0413, 1, 0, 0, 5'd0);
    // lw x7 held then flushed: busy[7] released, addi x9,x7,0 accepted.
    step(1, 32'h0000_A383, 1, 0, 0, 5'd0);
    step(1, 32'h0003_8493, 0, 1, 0, 5'd0);
    step(1, 32'h0003_8493, 1, 0, 0, 5'd0);
    // Same-cycle writeback of x7 and accept writing x7: busy stays set.
    step(1, 32'h0030_0393, 1, 0, 1, 5'd7);
    step(1, 32'h0003_8513, 1, 0, 0, 5'd0);
    step(1, 32'h0003_8513, 1, 0, 0, 5'd0);
    // mul x1,x2,x3 and ebreak.
    step(1, 32'h0231_00B3, 1, 0, 0, 5'd0);
    step(1, 32'h0010_0073, 1, 0, 0, 5'd0);
    // Mid-stream reset while a bundle is valid.
    step(1, 32'h0050_0593, 1, 0, 0, 5'd0);
    @(posedge clk); #1;
    in_valid = 0; out_ready = 0; flush = 0; wb_valid = 0;
    chk("pre_reset_valid", 64'(out_valid), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_reset_valid", 64'(out_valid), 64'd0);
    chk("async_reset_ctrl", 64'(out_ctrl), 64'h0002);
    chk("async_reset_imm", out_imm, 64'd0);
    sb_q.delete();
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    step(1, 32'h0052_8333, 1, 0, 0, 5'd0);

    // Random phase.
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 3) != 0, rand_inst(), $urandom_range(0, 2) != 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)));
    end
    repeat (4) step(0, 32'h0, 1, 0, 0, 5'd0);
    chk("queue_drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
